// File: rtl/uart_pkg.sv
// uart_pkg: baud table, rate codes and FSM state type shared by the UART transmitter and receiver
package uart_pkg;
   localparam logic [1:0] RATE_9600   = 2'd0;
   localparam logic [1:0] RATE_19200  = 2'd1;
   localparam logic [1:0] RATE_57600  = 2'd2;
   localparam logic [1:0] RATE_115200 = 2'd3;
   localparam int BAUD_TABLE [4] = '{9600, 19200, 57600, 115200};
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
   function automatic logic [31:0] baud_div(input int clk_hz, input int rate);
      return 32'(clk_hz / BAUD_TABLE[rate]);
   endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-write, rate-select, status and serial-line signals of the UART transmitter
interface uart_tx_if;
   logic [7:0] iData;
   logic       iWRen;
   logic [1:0] iRate;
   logic       TX;
   logic       oFIFO_FULL;
   logic       oFIFO_EMPTY;
   logic       oBusy;
   modport master (output iData, iWRen, iRate, input TX, oFIFO_FULL, oFIFO_EMPTY, oBusy);
   modport slave  (input iData, iWRen, iRate, output TX, oFIFO_FULL, oFIFO_EMPTY, oBusy);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: power-of-two byte FIFO with wrapping pointers and an occupancy count
module uart_tx_fifo #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr, rd;
   logic [AW:0]   cnt;
   logic          push_ok, pop_ok;
   assign full    = cnt == (AW+1)'(FIFO_DEPTH);
   assign empty   = cnt == '0;
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd];
   // storage write; a push while full is dropped even if a pop happens in the same cycle
   always_ff @(posedge clk)
      if (push_ok && !reset) mem[wr] <= din;
   // pointers wrap naturally at the power-of-two depth; count tracks occupancy
   always_ff @(posedge clk)
      if (reset) begin
         wr  <= '0;
         rd  <= '0;
         cnt <= '0;
      end else begin
         if (push_ok) wr <= wr + AW'(1);
         if (pop_ok) rd <= rd + AW'(1);
         cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for an even-parity bit
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int FIFO_DEPTH = 8
) (
   input logic     clk,
   input logic     reset,
   uart_tx_if.slave bus
);
   localparam logic [31:0] DIV_TAB [4] = '{baud_div(CLK_HZ, 0), baud_div(CLK_HZ, 1),
                                          baud_div(CLK_HZ, 2), baud_div(CLK_HZ, 3)};
   uart_state_t state;
   logic [7:0]  fifo_data, dat;
   logic [31:0] div, cnt;
   logic [2:0]  idx;
   logic        fifo_empty, fifo_full, pop, tx, busy, bit_end;
   assign pop             = (state == IDLE) && !fifo_empty;
   assign bit_end         = cnt == div - 32'd1;
   assign bus.TX          = tx;
   assign bus.oBusy       = busy;
   assign bus.oFIFO_FULL  = fifo_full;
   assign bus.oFIFO_EMPTY = fifo_empty;
   uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (bus.iWRen),
      .pop  (pop),
      .din  (bus.iData),
      .dout (fifo_data),
      .full (fifo_full),
      .empty(fifo_empty)
   );
   // frame sequencer: byte and rate are latched at the pop, every bit lasts div clocks
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         tx    <= 1'b1;
         busy  <= 1'b0;
         cnt   <= '0;
         idx   <= '0;
         div   <= '0;
         dat   <= '0;
      end else begin
         cnt <= (state == IDLE || bit_end) ? '0 : cnt + 32'd1;
         case (state)
            IDLE: if (!fifo_empty) begin
               state <= START;
               tx    <= 1'b0;
               busy  <= 1'b1;
               dat   <= fifo_data;
               div   <= DIV_TAB[bus.iRate];
            end
            START: if (bit_end) begin
               state <= DATA;
               tx    <= dat[0];
               idx   <= '0;
            end
            DATA: if (bit_end) begin
               if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state <= PARITY;
                  tx    <= ^dat;
`else
                  state <= STOP;
                  tx    <= 1'b1;
`endif
               end else begin
                  idx <= idx + 3'd1;
                  tx  <= dat[idx + 3'd1];
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) begin
               state <= STOP;
               tx    <= 1'b1;
            end
`endif
            STOP: if (bit_end) begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx with directed and randomized byte streams
`timescale 1ns/1ps
module tb_uart_tx;
   localparam int CLK_HZ = 1_152_000;
   localparam int BAUDS [4] = '{9600, 19200, 57600, 115200};
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   logic clk = 1'b0;
   logic reset = 1'b1;
   int cyc = 0;
   int total = 0;
   int bad = 0;
   int wcyc = 0;
   logic [7:0] q [$];
   int st_cyc [$];
   int st_div [$];
   bit st_empty [$];
   bit in_frame = 1'b0;

   uart_tx_if bus();
   uart_tx #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // drives one write strobe for one cycle; acc says whether the model expects it stored
   task automatic wr(input logic [7:0] d, input bit acc);
      bus.iData = d;
      bus.iWRen = 1'b1;
      wcyc = cyc;
      if (acc) q.push_back(d);
      @(posedge clk); #1;
      bus.iWRen = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      bit done;
      n = 0;
      done = 0;
      while (!done && n < budget) begin
         @(posedge clk); #1;
         n++;
         done = bus.oBusy === 1'b0 && bus.oFIFO_EMPTY === 1'b1 && !in_frame && q.size() == 0;
      end
      if (!done) chk("idle_timeout", 0, 1);
   endtask

   task automatic wait_starts(input int n, input int budget);
      int k;
      k = 0;
      while (st_cyc.size() < n && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      if (st_cyc.size() < n) chk("start_timeout", st_cyc.size(), n);
   endtask

   // monitor: on each falling TX pops the expected byte and checks every clock of every bit
   initial begin : monitor
      int rp, dv;
      logic [7:0] dd;
      logic exp_b;
      bit ok, ab;
      rp = 0;
      forever begin
         @(negedge clk);
         if (!reset && !in_frame && bus.TX === 1'b0) begin
            in_frame = 1'b1;
            ab = 1'b0;
            dv = CLK_HZ / BAUDS[rp];
            st_cyc.push_back(cyc);
            st_div.push_back(dv);
            st_empty.push_back(bus.oFIFO_EMPTY);
            if (q.size() == 0) begin
               chk("unexpected_frame", 1, 0);
               dd = 8'h00;
            end else dd = q.pop_front();
            for (int b = 0; b < NB && !ab; b++) begin
               if (b == 0) exp_b = 1'b0;
               else if (b <= 8) exp_b = dd[b-1];
               else if (b == 9 && NB == 11) exp_b = ^dd;
               else exp_b = 1'b1;
               ok = 1'b1;
               for (int k = 0; k < dv; k++) begin
                  if (b > 0 || k > 0) @(negedge clk);
                  if (reset) begin
                     ab = 1'b1;
                     break;
                  end
                  if (bus.TX !== exp_b || bus.oBusy !== 1'b1) ok = 1'b0;
               end
               if (!ab) chk($sformatf("frame_%02h_bit%0d", dd, b), 32'(ok), 1);
            end
            if (!ab) begin
               @(negedge clk);
               chk("busy_low_after_stop", 32'(bus.oBusy), 0);
            end
            in_frame = 1'b0;
         end
         rp = int'(bus.iRate);
      end
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin : stim
      int base, s, n0;
      bus.iData = 8'h00;
      bus.iWRen = 1'b0;
      bus.iRate = 2'd0;
      repeat (2) @(posedge clk);
      bus.iWRen = 1'b1;
      @(negedge clk);
      chk("reset_tx", 32'(bus.TX), 1);
      chk("reset_busy", 32'(bus.oBusy), 0);
      chk("reset_empty", 32'(bus.oFIFO_EMPTY), 1);
      chk("reset_full", 32'(bus.oFIFO_FULL), 0);
      @(posedge clk); #1;
      bus.iWRen = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("empty_after_reset_write", 32'(bus.oFIFO_EMPTY), 1);
      // single 9600-rate frame and write-to-start latency
      bus.iRate = 2'd0;
      chk("idle_tx_high", 32'(bus.TX), 1);
      wr(8'h31, 1);
      wait_starts(1, 20);
      if (st_cyc.size() >= 1) begin
         chk("latency", st_cyc[0] - wcyc, 2);
         chk("div_9600", st_div[0], 120);
      end
      wait_idle(2000);
      // three back-to-back frames at 115200
      bus.iRate = 2'd3;
      base = st_cyc.size();
      wr(8'h32, 1);
      wr(8'h33, 1);
      wr(8'hA5, 1);
      wait_idle(1000);
      if (st_cyc.size() == base + 3) begin
         chk("gap_1_2", st_cyc[base+1] - st_cyc[base], NB * 10 + 1);
         chk("gap_2_3", st_cyc[base+2] - st_cyc[base+1], NB * 10 + 1);
         chk("div_115200", st_div[base+2], 10);
         chk("empty_after_third_pop", 32'(st_empty[base+2]), 1);
      end else chk("b2b_frame_count", st_cyc.size() - base, 3);
      // overfill while a frame is active: 8 stored, 9th dropped
      base = st_cyc.size();
      wr(8'h40, 1);
      wait_starts(base + 1, 20);
      for (int i = 0; i < 9; i++) begin
         wr(8'h80 + 8'(i), i < 8);
         if (i == 6) chk("not_full_at_7", 32'(bus.oFIFO_FULL), 0);
         if (i == 7) chk("full_at_8", 32'(bus.oFIFO_FULL), 1);
         if (i == 8) chk("full_after_drop", 32'(bus.oFIFO_FULL), 1);
      end
      wait_idle(3000);
      chk("overfill_frames", st_cyc.size() - base, 9);
      // reset during data bit 4 of 0x55 with a second byte queued
      wr(8'h55, 1);
      wr(8'h12, 1);
      wait_starts(st_cyc.size() + 1, 20);
      s = st_cyc[st_cyc.size()-1];
      while (cyc < s + 52) @(posedge clk);
      #1;
      reset = 1'b1;
      bus.iData = 8'h77;
      bus.iWRen = 1'b1;
      q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      bus.iWRen = 1'b0;
      @(negedge clk);
      chk("abort_tx_high", 32'(bus.TX), 1);
      chk("abort_empty", 32'(bus.oFIFO_EMPTY), 1);
      chk("abort_busy", 32'(bus.oBusy), 0);
      n0 = st_cyc.size();
      repeat (400) @(posedge clk);
      #1;
      chk("no_frame_after_abort", st_cyc.size(), n0);
      // rate change mid-frame applies only to the next frame
      bus.iRate = 2'd0;
      base = st_cyc.size();
      wr(8'h0F, 1);
      wait_starts(base + 1, 20);
      repeat (200) @(posedge clk);
      #1;
      bus.iRate = 2'd3;
      wr(8'hF0, 1);
      wait_idle(3000);
      if (st_cyc.size() == base + 2) begin
         chk("rate_old_frame", st_div[base], 120);
         chk("rate_new_frame", st_div[base+1], 10);
      end else chk("rate_frame_count", st_cyc.size() - base, 2);
      // parity-sensitive bytes (odd and even weight)
      wr(8'h07, 1);
      wr(8'h03, 1);
      wait_idle(1000);
      // randomized bursts with random rates, occasionally changed mid-burst
      for (int bst = 0; bst < 6; bst++) begin
         bus.iRate = 2'($urandom_range(0, 3));
         for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
            wr(8'($urandom), 1);
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk); #1;
            end
            if ($urandom_range(0, 3) == 0) bus.iRate = 2'($urandom_range(0, 3));
         end
         wait_idle(7000);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
